// File: rtl/waveform_wr_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ recorder AXI write masters onto one
// AXI write master port, one transaction at a time, with per-requester burst length checks.
module waveform_wr_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 128
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]    s_AWADDR,
  input  logic [NUM_REQ*8-1:0]                 s_AWLEN,
  input  logic [NUM_REQ*3-1:0]                 s_AWSIZE,
  input  logic [NUM_REQ-1:0]                   s_AWVALID,
  output logic [NUM_REQ-1:0]                   s_AWREADY,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]    s_WDATA,
  input  logic [NUM_REQ*AXI_DATA_WIDTH/8-1:0]  s_WSTRB,
  input  logic [NUM_REQ-1:0]                   s_WLAST,
  input  logic [NUM_REQ-1:0]                   s_WVALID,
  output logic [NUM_REQ-1:0]                   s_WREADY,
  output logic [NUM_REQ*2-1:0]                 s_BRESP,
  output logic [NUM_REQ-1:0]                   s_BVALID,
  output logic [AXI_ADDR_WIDTH-1:0]            m_AWADDR,
  output logic [7:0]                           m_AWLEN,
  output logic [2:0]                           m_AWSIZE,
  output logic                                 m_AWVALID,
  input  logic                                 m_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]            m_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]          m_WSTRB,
  output logic                                 m_WLAST,
  output logic                                 m_WVALID,
  input  logic                                 m_WREADY,
  input  logic [1:0]                           m_BRESP,
  input  logic                                 m_BVALID,
  output logic                                 m_BREADY,
  output logic [NUM_REQ-1:0]                   grant,
  output logic                                 busy,
  output logic [NUM_REQ-1:0]                   lenError,
  input  logic                                 clearErrors
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t               state;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        gidx;
  logic [IW-1:0]        next_idx;
  logic                 found;
  int unsigned          cand;
  logic [7:0]           beat_cnt;
  logic                 aw_hs;
  logic                 w_hs;
  logic [NUM_REQ-1:0]   len_err_set;

  // Upward search with wrap, starting at the priority pointer.
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    cand     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr) + k) % NUM_REQ;
      if (!found && s_AWVALID[cand]) begin
        found    = 1'b1;
        next_idx = IW'(cand);
      end
    end
  end

  // Data fields are an AND-OR mux on the one-hot grant, so they read 0 when idle.
  always_comb begin
    m_AWADDR = '0;
    m_AWLEN  = '0;
    m_AWSIZE = '0;
    m_WDATA  = '0;
    m_WSTRB  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        m_AWADDR = s_AWADDR[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        m_AWLEN  = s_AWLEN[i*8 +: 8];
        m_AWSIZE = s_AWSIZE[i*3 +: 3];
        m_WDATA  = s_WDATA[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        m_WSTRB  = s_WSTRB[i*SW +: SW];
      end
    end
  end

  always_comb begin
    m_AWVALID = (state == S_ADDR) && |(s_AWVALID & grant);
    m_WVALID  = (state == S_DATA) && |(s_WVALID & grant);
    m_WLAST   = |(s_WLAST & grant);
    m_BREADY  = (state == S_RESP);
    s_AWREADY = (state == S_ADDR && m_AWREADY) ? grant : '0;
    s_WREADY  = (state == S_DATA && m_WREADY)  ? grant : '0;
    s_BVALID  = (state == S_RESP && m_BVALID)  ? grant : '0;
    s_BRESP   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i] && state == S_RESP) s_BRESP[i*2 +: 2] = m_BRESP;
    end
    aw_hs       = m_AWVALID && m_AWREADY;
    w_hs        = m_WVALID && m_WREADY;
    len_err_set = (w_hs && ((m_WLAST && beat_cnt != '0) || (!m_WLAST && beat_cnt == '0)))
                  ? grant : '0;
    busy        = (state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      gidx     <= '0;
      grant    <= '0;
      beat_cnt <= '0;
      lenError <= '0;
    end else begin
      lenError <= (clearErrors ? '0 : lenError) | len_err_set;
      case (state)
        S_IDLE: if (found) begin
          grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << next_idx;
          gidx  <= next_idx;
          state <= S_ADDR;
        end
        S_ADDR: if (aw_hs) begin
          beat_cnt <= m_AWLEN;
          state    <= S_DATA;
        end
        // Counter saturates at 0 so overrun beats keep flagging an error.
        S_DATA: if (w_hs) begin
          if (m_WLAST)               state    <= S_RESP;
          else if (beat_cnt != '0)   beat_cnt <= beat_cnt - 8'd1;
        end
        S_RESP: if (m_BVALID) begin
          ptr   <= (gidx == IW'(NUM_REQ-1)) ? '0 : gidx + IW'(1);
          grant <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_waveform_wr_arbiter.sv
// Directed bench for waveform_wr_arbiter: arbitration order, AW stall, B routing,
// burst length errors and mid-transaction reset.
module tb_waveform_wr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 128;

  logic               clk = 1'b0;
  logic               rst;
  logic [N*AW-1:0]    s_AWADDR;
  logic [N*8-1:0]     s_AWLEN;
  logic [N*3-1:0]     s_AWSIZE;
  logic [N-1:0]       s_AWVALID, s_AWREADY;
  logic [N*DW-1:0]    s_WDATA;
  logic [N*DW/8-1:0]  s_WSTRB;
  logic [N-1:0]       s_WLAST, s_WVALID, s_WREADY;
  logic [N*2-1:0]     s_BRESP;
  logic [N-1:0]       s_BVALID;
  logic [AW-1:0]      m_AWADDR;
  logic [7:0]         m_AWLEN;
  logic [2:0]         m_AWSIZE;
  logic               m_AWVALID, m_AWREADY;
  logic [DW-1:0]      m_WDATA;
  logic [DW/8-1:0]    m_WSTRB;
  logic               m_WLAST, m_WVALID, m_WREADY;
  logic [1:0]         m_BRESP;
  logic               m_BVALID, m_BREADY;
  logic [N-1:0]       grant, lenError;
  logic               busy, clearErrors;

  int checks = 0;
  int errors = 0;

  int r_g, r_wait, r_awhigh, r_awrdy, r_beats, r_lasts, r_bad;
  logic r_to, r_bready, r_idle_busy;
  logic [N-1:0]   r_bvalid, r_idle_grant;
  logic [1:0]     r_bresp;
  logic [N*2-1:0] r_bresp_all;
  logic [AW-1:0]  r_awaddr;

  waveform_wr_arbiter #(.NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_AWADDR(s_AWADDR), .s_AWLEN(s_AWLEN), .s_AWSIZE(s_AWSIZE),
    .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY),
    .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB), .s_WLAST(s_WLAST),
    .s_WVALID(s_WVALID), .s_WREADY(s_WREADY),
    .s_BRESP(s_BRESP), .s_BVALID(s_BVALID),
    .m_AWADDR(m_AWADDR), .m_AWLEN(m_AWLEN), .m_AWSIZE(m_AWSIZE),
    .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY),
    .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB), .m_WLAST(m_WLAST),
    .m_WVALID(m_WVALID), .m_WREADY(m_WREADY),
    .m_BRESP(m_BRESP), .m_BVALID(m_BVALID), .m_BREADY(m_BREADY),
    .grant(grant), .busy(busy), .lenError(lenError), .clearErrors(clearErrors)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int g, input int b);
    return DW'(32'h5A000000 + g * 65536 + b);
  endfunction

  // Plays both the granted recorder and the downstream slave for one transaction.
  task automatic serve(input int wlast_at, input logic [1:0] bresp, input int aw_delay,
                       input logic wstall, input int clr_beat);
    int n, beat;
    logic done;
    r_to = 0; r_g = -1; r_wait = 0; r_awhigh = 0; r_awrdy = 0;
    r_beats = 0; r_lasts = 0; r_bad = 0; r_bready = 0; r_bvalid = '0;
    r_bresp = '0; r_bresp_all = '0; r_idle_busy = 1; r_idle_grant = '1; r_awaddr = '0;
    m_AWREADY = 0;
    do begin @(negedge clk); #1; r_wait++; end while (!m_AWVALID && r_wait < 40);
    if (!m_AWVALID) begin r_to = 1; return; end
    for (int i = 0; i < N; i++) if (grant[i]) r_g = i;
    if (r_g < 0) begin r_to = 1; return; end
    n = 0;
    forever begin
      m_AWREADY = (n >= aw_delay);
      #1;
      if (m_AWVALID) r_awhigh++;
      if (s_AWREADY[r_g]) r_awrdy++;
      if (m_AWVALID && m_AWREADY) begin r_awaddr = m_AWADDR; break; end
      n++;
      if (n > 40) begin r_to = 1; m_AWREADY = 0; return; end
      @(negedge clk); #1;
    end
    @(negedge clk);
    m_AWREADY = 0;
    beat = 0; done = 0; n = 0;
    while (!done) begin
      m_WREADY    = !(wstall && (n % 2 == 1));
      clearErrors = (beat == clr_beat);
      s_WVALID[r_g] = 1'b1;
      s_WLAST[r_g]  = (beat == wlast_at);
      s_WDATA[r_g*DW +: DW] = pat(r_g, beat);
      #1;
      if (m_WVALID && m_WREADY) begin
        r_beats++;
        if (m_WLAST) r_lasts++;
        if (m_WDATA !== pat(r_g, beat)) r_bad++;
        done = s_WLAST[r_g];
        beat++;
      end
      n++;
      if (n > 400) begin r_to = 1; done = 1; end
      @(negedge clk);
    end
    clearErrors = 0; s_WVALID[r_g] = 1'b0; s_WLAST[r_g] = 1'b0; m_WREADY = 1;
    if (r_to) return;
    #1;
    r_bready = m_BREADY;
    m_BVALID = 1; m_BRESP = bresp;
    #1;
    r_bvalid = s_BVALID; r_bresp_all = s_BRESP; r_bresp = s_BRESP[r_g*2 +: 2];
    @(negedge clk);
    m_BVALID = 0; m_BRESP = '0;
    #1;
    r_idle_busy = busy; r_idle_grant = grant;
  endtask

  task automatic test_reset;
    rst = 1;
    s_AWADDR = '0; s_AWLEN = '0; s_AWSIZE = '0; s_AWVALID = '0;
    s_WDATA = '0; s_WSTRB = '1; s_WLAST = '0; s_WVALID = '0;
    m_AWREADY = 0; m_WREADY = 1; m_BRESP = '0; m_BVALID = 0; clearErrors = 0;
    for (int i = 0; i < N; i++) begin
      s_AWADDR[i*AW +: AW] = AW'(32'h1000 * (i + 1));
      s_AWSIZE[i*3 +: 3]   = 3'd4;
    end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", grant); end
    checks++; if (lenError !== 4'b0000) begin errors++; $display("FAIL reset_lenError got %b exp 0000", lenError); end
    checks++; if ({m_AWVALID, m_WVALID, m_BREADY} !== 3'b000) begin errors++; $display("FAIL reset_mvalid got %b exp 000", {m_AWVALID, m_WVALID, m_BREADY}); end
    checks++; if ({s_AWREADY, s_WREADY, s_BVALID} !== 12'h000) begin errors++; $display("FAIL reset_sready got %h exp 000", {s_AWREADY, s_WREADY, s_BVALID}); end
    checks++; if (m_AWADDR !== 32'h0) begin errors++; $display("FAIL reset_awaddr got %h exp 0", m_AWADDR); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_round_robin;
    int exp_g[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) s_AWLEN[i*8 +: 8] = 8'd7;
    s_AWVALID = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      serve(7, 2'b00, 0, k[0], -1);
      checks++; if (r_to !== 1'b0) begin errors++; $display("FAIL rr_timeout[%0d] got %b exp 0", k, r_to); end
      checks++; if (r_g !== exp_g[k]) begin errors++; $display("FAIL rr_grant[%0d] got %0d exp %0d", k, r_g, exp_g[k]); end
      checks++; if (r_wait !== 1) begin errors++; $display("FAIL rr_latency[%0d] got %0d exp 1", k, r_wait); end
      checks++; if (r_beats !== 8 || r_lasts !== 1) begin errors++; $display("FAIL rr_beats[%0d] got %0d/%0d exp 8/1", k, r_beats, r_lasts); end
      checks++; if (r_bad !== 0) begin errors++; $display("FAIL rr_data[%0d] got %0d bad exp 0", k, r_bad); end
      checks++; if (r_idle_busy !== 1'b0 || r_idle_grant !== 4'b0000) begin errors++; $display("FAIL rr_idle_gap[%0d] got busy %b grant %b exp 0 0000", k, r_idle_busy, r_idle_grant); end
    end
    s_AWVALID = '0;
    checks++; if (lenError !== 4'b0000) begin errors++; $display("FAIL rr_lenError got %b exp 0000", lenError); end
  endtask

  task automatic test_aw_stall;
    s_AWLEN[2*8 +: 8] = 8'd1;
    s_AWVALID = 4'b0100;
    serve(1, 2'b00, 5, 1'b0, -1);
    s_AWVALID = '0;
    checks++; if (r_g !== 2) begin errors++; $display("FAIL stall_grant got %0d exp 2", r_g); end
    checks++; if (r_awhigh !== 6) begin errors++; $display("FAIL stall_awvalid_cycles got %0d exp 6", r_awhigh); end
    checks++; if (r_awrdy !== 1) begin errors++; $display("FAIL stall_awready_pulses got %0d exp 1", r_awrdy); end
    checks++; if (r_awaddr !== 32'h3000) begin errors++; $display("FAIL stall_awaddr got %h exp 00003000", r_awaddr); end
    checks++; if (r_beats !== 2 || r_bad !== 0) begin errors++; $display("FAIL stall_beats got %0d bad %0d exp 2 bad 0", r_beats, r_bad); end
  endtask

  task automatic test_bresp;
    s_AWLEN[1*8 +: 8] = 8'd0;
    s_AWVALID = 4'b0010;
    serve(0, 2'b10, 0, 1'b0, -1);
    s_AWVALID = '0;
    checks++; if (r_g !== 1) begin errors++; $display("FAIL bresp_grant got %0d exp 1", r_g); end
    checks++; if (r_bready !== 1'b1) begin errors++; $display("FAIL bresp_bready got %b exp 1", r_bready); end
    checks++; if (r_bvalid !== 4'b0010) begin errors++; $display("FAIL bresp_bvalid got %b exp 0010", r_bvalid); end
    checks++; if (r_bresp_all !== 8'b00_00_10_00) begin errors++; $display("FAIL bresp_all got %b exp 00001000", r_bresp_all); end
    checks++; if (lenError !== 4'b0000) begin errors++; $display("FAIL bresp_lenError got %b exp 0000", lenError); end
  endtask

  task automatic test_len_error;
    s_AWLEN[3*8 +: 8] = 8'd7;
    s_AWVALID = 4'b1000;
    serve(5, 2'b00, 0, 1'b0, -1);
    s_AWVALID = '0;
    checks++; if (r_beats !== 6 || r_lasts !== 1) begin errors++; $display("FAIL short_beats got %0d/%0d exp 6/1", r_beats, r_lasts); end
    checks++; if (lenError !== 4'b1000) begin errors++; $display("FAIL short_lenError got %b exp 1000", lenError); end
    checks++; if (r_idle_busy !== 1'b0) begin errors++; $display("FAIL short_idle got busy %b exp 0", r_idle_busy); end
    // clear coincides with a new error on requester 1: bit 3 clears, bit 1 sets
    s_AWLEN[1*8 +: 8] = 8'd3;
    s_AWVALID = 4'b0010;
    serve(1, 2'b00, 0, 1'b0, 1);
    s_AWVALID = '0;
    checks++; if (lenError !== 4'b0010) begin errors++; $display("FAIL setwins_lenError got %b exp 0010", lenError); end
    @(negedge clk); clearErrors = 1;
    @(negedge clk); clearErrors = 0; #1;
    checks++; if (lenError !== 4'b0000) begin errors++; $display("FAIL clear_lenError got %b exp 0000", lenError); end
    s_AWLEN[0*8 +: 8] = 8'd0;
    s_AWVALID = 4'b0001;
    serve(2, 2'b00, 0, 1'b1, -1);
    s_AWVALID = '0;
    checks++; if (r_beats !== 3 || r_lasts !== 1) begin errors++; $display("FAIL long_beats got %0d/%0d exp 3/1", r_beats, r_lasts); end
    checks++; if (lenError !== 4'b0001) begin errors++; $display("FAIL long_lenError got %b exp 0001", lenError); end
    @(negedge clk); clearErrors = 1;
    @(negedge clk); clearErrors = 0;
    s_AWLEN[2*8 +: 8] = 8'd255;
    s_AWVALID = 4'b0100;
    serve(255, 2'b00, 0, 1'b0, -1);
    s_AWVALID = '0;
    checks++; if (r_beats !== 256 || r_bad !== 0) begin errors++; $display("FAIL len255_beats got %0d bad %0d exp 256 bad 0", r_beats, r_bad); end
    checks++; if (lenError !== 4'b0000) begin errors++; $display("FAIL len255_lenError got %b exp 0000", lenError); end
  endtask

  task automatic test_reset_mid;
    int n, hs;
    s_AWLEN[3*8 +: 8] = 8'd63;
    s_AWVALID = 4'b1000;
    m_AWREADY = 1;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!m_AWVALID && n < 20);
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL mid_grant got %b exp 1000", grant); end
    @(negedge clk);
    s_AWVALID = '0; m_AWREADY = 0;
    s_WVALID[3] = 1'b1;
    hs = 0;
    for (int b = 0; b < 3; b++) begin
      s_WDATA[3*DW +: DW] = pat(3, b);
      #1;
      if (m_WVALID && m_WREADY) hs++;
      @(negedge clk);
    end
    checks++; if (hs !== 3) begin errors++; $display("FAIL mid_beats got %0d exp 3", hs); end
    #1; rst = 1; #1;
    checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin errors++; $display("FAIL mid_async got busy %b grant %b exp 0 0000", busy, grant); end
    @(negedge clk); @(negedge clk);
    rst = 0;
    hs = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (m_WVALID || s_WREADY != '0 || m_AWVALID || m_BREADY) hs++;
      @(negedge clk);
    end
    checks++; if (hs !== 0) begin errors++; $display("FAIL mid_abandon got %0d active cycles exp 0", hs); end
    s_WVALID = '0;
    s_AWLEN[0*8 +: 8] = 8'd1;
    s_AWLEN[2*8 +: 8] = 8'd1;
    s_AWVALID = 4'b0101;
    serve(1, 2'b00, 0, 1'b0, -1);
    s_AWVALID = '0;
    checks++; if (r_g !== 0) begin errors++; $display("FAIL mid_next_grant got %0d exp 0", r_g); end
    checks++; if (r_beats !== 2 || lenError !== 4'b0000) begin errors++; $display("FAIL mid_next_burst got %0d beats lenError %b exp 2 0000", r_beats, lenError); end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_aw_stall;
    test_bresp;
    test_len_error;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
